// File: rtl/noc_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkt_pkg
// Description : Shared definitions for the NoC packet creator. Contains the
//               flit type codes, the packetiser FSM state encoding and a
//               helper that locates each header field inside a flit.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkt_pkg;

    // Flit type codes carried on network_flit_type_o
    localparam logic [1:0] c_FLIT_HEADER = 2'b00;
    localparam logic [1:0] c_FLIT_BODY   = 2'b01;
    localparam logic [1:0] c_FLIT_TAIL   = 2'b10;

    // Packetiser FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_SPLIT = 2'd2
    } state_e;

    // Header fields, listed from the MSB of the flit downwards
    typedef enum logic [1:0] {
        HDR_TDEST = 2'd0,
        HDR_SRC   = 2'd1,
        HDR_TID   = 2'd2,
        HDR_CONT  = 2'd3
    } hdr_field_e;

    // LSB position of a header field. Layout from the MSB down:
    // {tdest, source id, tid, cont, zeros}
    function automatic int hdr_lsb(input int noc_w, input int node_w,
                                   input int tid_w, input hdr_field_e f);
        int lsb;
        case (f)
            HDR_TDEST: lsb = noc_w - node_w;
            HDR_SRC:   lsb = noc_w - 2 * node_w;
            HDR_TID:   lsb = noc_w - 2 * node_w - tid_w;
            default:   lsb = noc_w - 2 * node_w - tid_w - 1;
        endcase
        return lsb;
    endfunction

endpackage : noc_pkt_pkg
`default_nettype wire

// File: rtl/noc_flit_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : noc_flit_out_reg
// Description : One-entry valid/ready output register holding a flit together
//               with its type, virtual channel and valid byte count.
//               o_free is high when the entry may be (re)loaded this cycle:
//               either it is empty or its content is leaving right now.
// Ports       : clk, rst_n (async, active-low)
//               i_load + i_flit/i_type/i_vc/i_bytes : new entry (only when free)
//               o_flit/o_type/o_vc/o_bytes/o_valid, i_ready : NoC side
//               o_free : entry can accept a load this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module noc_flit_out_reg #(
    parameter int DATA_W  = 64,
    parameter int TYPE_W  = 2,
    parameter int VC_W    = 3,
    parameter int BYTES_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [DATA_W-1:0]  i_flit,
    input  logic [TYPE_W-1:0]  i_type,
    input  logic [VC_W-1:0]    i_vc,
    input  logic [BYTES_W-1:0] i_bytes,
    output logic               o_free,
    output logic [DATA_W-1:0]  o_flit,
    output logic [TYPE_W-1:0]  o_type,
    output logic [VC_W-1:0]    o_vc,
    output logic [BYTES_W-1:0] o_bytes,
    output logic               o_valid,
    input  logic               i_ready
);

    logic               r_valid;
    logic [DATA_W-1:0]  r_flit;
    logic [TYPE_W-1:0]  r_type;
    logic [VC_W-1:0]    r_vc;
    logic [BYTES_W-1:0] r_bytes;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_flit  <= '0;
            r_type  <= '0;
            r_vc    <= '0;
            r_bytes <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_flit  <= i_flit;
            r_type  <= i_type;
            r_vc    <= i_vc;
            r_bytes <= i_bytes;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_free  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_flit  = r_flit;
    assign o_type  = r_type;
    assign o_vc    = r_vc;
    assign o_bytes = r_bytes;

endmodule : noc_flit_out_reg
`default_nettype wire

// File: rtl/noc_packet_creator_gen.sv
`default_nettype none
// ============================================================================
// Module      : noc_packet_creator_gen
// Description : AXI-Stream to NoC packetiser. Packs AXIS beats into NoC flits,
//               prefixes each packet with a header flit and splits messages
//               into packets of at most MAX_PAYLOAD_FLITS payload flits.
//               Each flit reports its number of valid payload bytes.
// Ports       : s_axis_aclk, s_axis_arstn (async, active-low)
//               s_axis_t{data,valid,ready,last,id,dest} : AXIS slave
//               network_{flit,flit_type,vc,bytes,valid}_o,
//               network_ready_i                         : NoC master
//               stat_packets_o, stat_flits_o            : only with
//                                                       NOC_PKT_CREATOR_STATS_EN
// Options     : `define NOC_PKT_CREATOR_STATS_EN to add packet/flit counters.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_packet_creator_gen
    import noc_pkt_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH              = 8,
    parameter int NOC_DATA_WIDTH               = 64,
    parameter int NUM_VN                       = 3,
    parameter int TID_WIDTH                    = 8,
    parameter int TDEST_WIDTH                  = 11,
    parameter int SOURCE_ID                    = 0,
    parameter int MAX_PAYLOAD_FLITS            = 16,
    parameter int NOC_VIRTUAL_CHANNEL_ID_WIDTH = 3,
    parameter int FLIT_TYPE_SIZE               = 2
) (
    input  logic                                    s_axis_aclk,
    input  logic                                    s_axis_arstn,
    input  logic [AXIS_DATA_WIDTH-1:0]              s_axis_tdata,
    input  logic                                    s_axis_tvalid,
    output logic                                    s_axis_tready,
    input  logic                                    s_axis_tlast,
    input  logic [TID_WIDTH-1:0]                    s_axis_tid,
    input  logic [TDEST_WIDTH-1:0]                  s_axis_tdest,
    output logic [NOC_DATA_WIDTH-1:0]               network_flit_o,
    output logic [FLIT_TYPE_SIZE-1:0]               network_flit_type_o,
    output logic [NOC_VIRTUAL_CHANNEL_ID_WIDTH-1:0] network_vc_o,
    output logic [$clog2(NOC_DATA_WIDTH/8):0]       network_bytes_o,
    output logic                                    network_valid_o,
    input  logic                                    network_ready_i
`ifdef NOC_PKT_CREATOR_STATS_EN
    ,
    output logic [31:0]                             stat_packets_o,
    output logic [31:0]                             stat_flits_o
`endif
);

    localparam int c_BEATS      = NOC_DATA_WIDTH / AXIS_DATA_WIDTH;
    localparam int c_BEAT_BYTES = AXIS_DATA_WIDTH / 8;
    localparam int c_BYTES_W    = $clog2(NOC_DATA_WIDTH / 8) + 1;
    localparam int c_LANE_W     = $clog2(c_BEATS) + 1;
    localparam int c_VC_W       = NOC_VIRTUAL_CHANNEL_ID_WIDTH;
    localparam int c_TDEST_LSB  = hdr_lsb(NOC_DATA_WIDTH, TDEST_WIDTH, TID_WIDTH, HDR_TDEST);
    localparam int c_SRC_LSB    = hdr_lsb(NOC_DATA_WIDTH, TDEST_WIDTH, TID_WIDTH, HDR_SRC);
    localparam int c_TID_LSB    = hdr_lsb(NOC_DATA_WIDTH, TDEST_WIDTH, TID_WIDTH, HDR_TID);
    localparam int c_CONT_LSB   = hdr_lsb(NOC_DATA_WIDTH, TDEST_WIDTH, TID_WIDTH, HDR_CONT);

    state_e                      r_state;
    state_e                      w_state_next;
    logic [NOC_DATA_WIDTH-1:0]   r_pack;
    logic [c_LANE_W-1:0]         r_lane;
    logic [c_BYTES_W-1:0]        r_bytes;
    logic                        r_complete;
    logic                        r_last;
    logic [7:0]                  r_flit_cnt;
    logic [TID_WIDTH-1:0]        r_tid;
    logic [TDEST_WIDTH-1:0]      r_tdest;
    logic [c_VC_W-1:0]           r_vc;

    logic                        w_out_free;
    logic                        w_out_load;
    logic                        w_hdr_load;
    logic                        w_pack_xfer;
    logic                        w_limit;
    logic                        w_tready;
    logic                        w_beat;
    logic [NOC_DATA_WIDTH-1:0]   w_hdr;
    logic [TID_WIDTH-1:0]        w_hdr_tid;
    logic [TDEST_WIDTH-1:0]      w_hdr_tdest;
    logic [c_VC_W-1:0]           w_vc_in;
    logic [NOC_DATA_WIDTH-1:0]   w_out_flit;
    logic [FLIT_TYPE_SIZE-1:0]   w_out_type;
    logic [c_VC_W-1:0]           w_out_vc;
    logic [c_BYTES_W-1:0]        w_out_bytes;
    logic [NOC_DATA_WIDTH-1:0]   w_pack_base;
    logic [c_LANE_W-1:0]         w_lane_base;
    logic [c_BYTES_W-1:0]        w_bytes_base;
    logic [NOC_DATA_WIDTH-1:0]   w_pack_next;
    logic [c_LANE_W-1:0]         w_lane_next;
    logic [c_BYTES_W-1:0]        w_bytes_next;
    logic                        w_complete_next;
    logic                        w_last_next;

    // The flit about to leave the pack register is the last one allowed in
    // this packet.
    assign w_limit     = ({1'b0, r_flit_cnt} + 9'd1) == 9'(MAX_PAYLOAD_FLITS);
    assign w_pack_xfer = (r_state == ST_PACK) && r_complete && w_out_free;
    assign w_vc_in     = c_VC_W'(32'(s_axis_tid) % NUM_VN);

    // ------------------------------------------------------------------
    // FSM: next state and input handshake
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_tready     = 1'b0;
        w_hdr_load   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // First beat needs the output register for its header.
                w_tready = w_out_free;
                if (s_axis_tvalid && w_out_free) begin
                    w_hdr_load   = 1'b1;
                    w_state_next = ST_PACK;
                end
            end
            ST_PACK: begin
                // A new beat may enter the pack register in the same cycle
                // the completed flit leaves, unless that flit closes the
                // packet: the next beat then has to wait for a header.
                w_tready = !r_complete || (w_out_free && !r_last && !w_limit);
                if (w_pack_xfer) begin
                    if (r_last) begin
                        w_state_next = ST_IDLE;
                    end else if (w_limit) begin
                        w_state_next = ST_SPLIT;
                    end
                end
            end
            ST_SPLIT: begin
                if (w_out_free) begin
                    w_hdr_load   = 1'b1;
                    w_state_next = ST_PACK;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign s_axis_tready = w_tready;
    assign w_beat        = s_axis_tvalid && w_tready;

    always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
        if (!s_axis_arstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Header construction: on the first beat the id/dest come straight
    // from the bus; continuation headers reuse the latched values.
    // ------------------------------------------------------------------
    assign w_hdr_tid   = (r_state == ST_IDLE) ? s_axis_tid   : r_tid;
    assign w_hdr_tdest = (r_state == ST_IDLE) ? s_axis_tdest : r_tdest;

    always_comb begin
        w_hdr                                  = '0;
        w_hdr[c_TDEST_LSB +: TDEST_WIDTH]      = w_hdr_tdest;
        w_hdr[c_SRC_LSB +: TDEST_WIDTH]        = TDEST_WIDTH'(SOURCE_ID);
        w_hdr[c_TID_LSB +: TID_WIDTH]          = w_hdr_tid;
        w_hdr[c_CONT_LSB]                      = (r_state == ST_SPLIT);
    end

    // ------------------------------------------------------------------
    // Output register source select
    // ------------------------------------------------------------------
    assign w_out_load  = w_hdr_load || w_pack_xfer;
    assign w_out_flit  = w_hdr_load ? w_hdr : r_pack;
    assign w_out_vc    = (r_state == ST_IDLE) ? w_vc_in : r_vc;
    assign w_out_bytes = w_hdr_load ? '0 : r_bytes;

    always_comb begin
        if (w_hdr_load) begin
            w_out_type = FLIT_TYPE_SIZE'(c_FLIT_HEADER);
        end else if (r_last || w_limit) begin
            w_out_type = FLIT_TYPE_SIZE'(c_FLIT_TAIL);
        end else begin
            w_out_type = FLIT_TYPE_SIZE'(c_FLIT_BODY);
        end
    end

    // ------------------------------------------------------------------
    // Pack register: when the held flit leaves this cycle, an incoming
    // beat starts a fresh flit at lane 0.
    // ------------------------------------------------------------------
    assign w_pack_base  = w_pack_xfer ? '0 : r_pack;
    assign w_lane_base  = w_pack_xfer ? '0 : r_lane;
    assign w_bytes_base = w_pack_xfer ? '0 : r_bytes;

    always_comb begin
        w_pack_next     = w_pack_base;
        w_lane_next     = w_lane_base;
        w_bytes_next    = w_bytes_base;
        w_complete_next = w_pack_xfer ? 1'b0 : r_complete;
        w_last_next     = w_pack_xfer ? 1'b0 : r_last;
        if (w_beat) begin
            // Unused upper lanes stay zero for a partial last flit.
            w_pack_next     = w_pack_base
                            | (NOC_DATA_WIDTH'(s_axis_tdata) << (w_lane_base * AXIS_DATA_WIDTH));
            w_lane_next     = w_lane_base + 1'b1;
            w_bytes_next    = w_bytes_base + c_BYTES_W'(c_BEAT_BYTES);
            w_complete_next = ((w_lane_base + 1'b1) == c_LANE_W'(c_BEATS)) || s_axis_tlast;
            w_last_next     = s_axis_tlast;
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
        if (!s_axis_arstn) begin
            r_pack     <= '0;
            r_lane     <= '0;
            r_bytes    <= '0;
            r_complete <= 1'b0;
            r_last     <= 1'b0;
            r_flit_cnt <= '0;
            r_tid      <= '0;
            r_tdest    <= '0;
            r_vc       <= '0;
        end else begin
            r_pack     <= w_pack_next;
            r_lane     <= w_lane_next;
            r_bytes    <= w_bytes_next;
            r_complete <= w_complete_next;
            r_last     <= w_last_next;
            if (w_hdr_load) begin
                r_flit_cnt <= '0;
            end else if (w_pack_xfer) begin
                r_flit_cnt <= r_flit_cnt + 8'd1;
            end
            // id/dest belong to the message: only the first beat counts.
            if ((r_state == ST_IDLE) && w_beat) begin
                r_tid   <= s_axis_tid;
                r_tdest <= s_axis_tdest;
                r_vc    <= w_vc_in;
            end
        end
    end

    noc_flit_out_reg #(
        .DATA_W  (NOC_DATA_WIDTH),
        .TYPE_W  (FLIT_TYPE_SIZE),
        .VC_W    (c_VC_W),
        .BYTES_W (c_BYTES_W)
    ) u_out_reg (
        .clk     (s_axis_aclk),
        .rst_n   (s_axis_arstn),
        .i_load  (w_out_load),
        .i_flit  (w_out_flit),
        .i_type  (w_out_type),
        .i_vc    (w_out_vc),
        .i_bytes (w_out_bytes),
        .o_free  (w_out_free),
        .o_flit  (network_flit_o),
        .o_type  (network_flit_type_o),
        .o_vc    (network_vc_o),
        .o_bytes (network_bytes_o),
        .o_valid (network_valid_o),
        .i_ready (network_ready_i)
    );

`ifdef NOC_PKT_CREATOR_STATS_EN
    logic [31:0] r_stat_packets;
    logic [31:0] r_stat_flits;

    always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
        if (!s_axis_arstn) begin
            r_stat_packets <= '0;
            r_stat_flits   <= '0;
        end else if (network_valid_o && network_ready_i) begin
            r_stat_flits <= r_stat_flits + 32'd1;
            if (network_flit_type_o == FLIT_TYPE_SIZE'(c_FLIT_HEADER)) begin
                r_stat_packets <= r_stat_packets + 32'd1;
            end
        end
    end

    assign stat_packets_o = r_stat_packets;
    assign stat_flits_o   = r_stat_flits;
`endif

endmodule : noc_packet_creator_gen
`default_nettype wire

// File: tb/tb_noc_packet_creator_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_packet_creator_gen
// Description : Self-checking bench for noc_packet_creator_gen (8-bit beats,
//               64-bit flits, packets of at most 2 payload flits). Stimulus
//               pushes the expected flit sequence of each message into a
//               queue; a monitor pops and compares every accepted flit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_packet_creator_gen;

    localparam int SRC  = 3;
    localparam int MAXP = 2;

    typedef struct {
        logic [63:0] flit;
        logic [1:0]  typ;
        logic [2:0]  vc;
        logic [3:0]  bytes;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [7:0]  s_axis_tid;
    logic [10:0] s_axis_tdest;
    logic [63:0] network_flit_o;
    logic [1:0]  network_flit_type_o;
    logic [2:0]  network_vc_o;
    logic [3:0]  network_bytes_o;
    logic        network_valid_o;
    logic        network_ready_i;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_pass     = 0;
    int   ready_mode = 1;   // 0: low, 1: high, 2: random
    bit   gap_en     = 1'b0;

    noc_packet_creator_gen #(
        .AXIS_DATA_WIDTH              (8),
        .NOC_DATA_WIDTH               (64),
        .NUM_VN                       (3),
        .TID_WIDTH                    (8),
        .TDEST_WIDTH                  (11),
        .SOURCE_ID                    (SRC),
        .MAX_PAYLOAD_FLITS            (MAXP),
        .NOC_VIRTUAL_CHANNEL_ID_WIDTH (3),
        .FLIT_TYPE_SIZE               (2)
    ) dut (
        .s_axis_aclk         (clk),
        .s_axis_arstn        (rst_n),
        .s_axis_tdata        (s_axis_tdata),
        .s_axis_tvalid       (s_axis_tvalid),
        .s_axis_tready       (s_axis_tready),
        .s_axis_tlast        (s_axis_tlast),
        .s_axis_tid          (s_axis_tid),
        .s_axis_tdest        (s_axis_tdest),
        .network_flit_o      (network_flit_o),
        .network_flit_type_o (network_flit_type_o),
        .network_vc_o        (network_vc_o),
        .network_bytes_o     (network_bytes_o),
        .network_valid_o     (network_valid_o),
        .network_ready_i     (network_ready_i)
    );

    initial forever #5 clk = ~clk;

    // NoC ready driver
    initial begin
        network_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       network_ready_i = 1'b0;
                1:       network_ready_i = 1'b1;
                default: network_ready_i = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic abort(input string name);
        n_checks++;
        $display("FAIL %s: wait bound expired, got timeout expected progress", name);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    // Reference model: split the message into 8-byte chunks, group chunks
    // into packets of MAXP, each packet preceded by its header.
    task automatic model_msg(input byte unsigned data[$], input logic [7:0] tid,
                             input logic [10:0] dest);
        int   n       = data.size();
        int   nchunks = (n + 7) / 8;
        exp_t e;
        for (int c = 0; c < nchunks; c++) begin
            if (c % MAXP == 0) begin
                e.flit  = (64'(dest) << 53) | (64'(SRC) << 42) | (64'(tid) << 34)
                        | (64'(c != 0) << 33);
                e.typ   = 2'd0;
                e.vc    = 3'(tid % 3);
                e.bytes = 4'd0;
                exp_q.push_back(e);
            end
            e.flit  = '0;
            e.bytes = 4'd0;
            for (int b = 0; b < 8; b++) begin
                if (c * 8 + b < n) begin
                    e.flit  = e.flit | (64'(data[c * 8 + b]) << (8 * b));
                    e.bytes = e.bytes + 4'd1;
                end
            end
            e.typ = ((c == nchunks - 1) || (c % MAXP == MAXP - 1)) ? 2'd2 : 2'd1;
            e.vc  = 3'(tid % 3);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_accept();
        int cyc = 0;
        @(negedge clk);
        while (!s_axis_tready) begin
            cyc++;
            if (cyc > 3000) abort("tready_wait");
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1. Later beats carry junk tid/tdest, which must be ignored.
    task automatic send_msg(input int n, input logic [7:0] tid, input logic [10:0] dest);
        byte unsigned d[$];
        for (int i = 0; i < n; i++) d.push_back(8'($urandom_range(0, 255)));
        model_msg(d, tid, dest);
        for (int i = 0; i < n; i++) begin
            if (gap_en && ($urandom_range(0, 3) == 0)) begin
                s_axis_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = d[i];
            s_axis_tlast  = (i == n - 1);
            s_axis_tid    = (i == 0) ? tid  : 8'($urandom);
            s_axis_tdest  = (i == 0) ? dest : 11'($urandom);
            wait_accept();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc > 5000) abort("drain");
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard compare on every accepted flit, plus a check that
    // a stalled flit stays put until taken.
    exp_t        m_e;
    bit          m_stalled = 1'b0;
    logic [63:0] m_flit;
    logic [1:0]  m_type;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_stalled = 1'b0;
        end else begin
            if (m_stalled) begin
                n_checks++;
                if (network_valid_o && network_flit_o == m_flit && network_flit_type_o == m_type)
                    n_pass++;
                else
                    $display("FAIL hold_stable: got valid=%0b flit=%h type=%0d expected valid=1 flit=%h type=%0d",
                             network_valid_o, network_flit_o, network_flit_type_o, m_flit, m_type);
            end
            if (network_valid_o && network_ready_i) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_flit: got flit=%h type=%0d expected no flit",
                             network_flit_o, network_flit_type_o);
                end else begin
                    m_e = exp_q.pop_front();
                    if (network_flit_o === m_e.flit && network_flit_type_o === m_e.typ &&
                        network_vc_o === m_e.vc && network_bytes_o === m_e.bytes)
                        n_pass++;
                    else
                        $display("FAIL flit: got flit=%h type=%0d vc=%0d bytes=%0d expected flit=%h type=%0d vc=%0d bytes=%0d",
                                 network_flit_o, network_flit_type_o, network_vc_o, network_bytes_o,
                                 m_e.flit, m_e.typ, m_e.vc, m_e.bytes);
                end
            end
            m_stalled = network_valid_o && !network_ready_i;
            m_flit    = network_flit_o;
            m_type    = network_flit_type_o;
        end
    end

    initial begin
        rst_n         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tid    = '0;
        s_axis_tdest  = '0;
        ready_mode    = 1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tready", 64'(s_axis_tready), 64'd1);
        check("rst_valid",  64'(network_valid_o), 64'd0);
        check("rst_flit",   network_flit_o, 64'd0);
        check("rst_type",   64'(network_flit_type_o), 64'd0);
        check("rst_vc",     64'(network_vc_o), 64'd0);
        check("rst_bytes",  64'(network_bytes_o), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed messages
        send_msg(12, 8'd4, 11'd5);   // header, body 8, tail 4
        send_msg(24, 8'd7, 11'd9);   // split: H B T H(cont) T
        send_msg(16, 8'd2, 11'd1);   // last beat on boundary and limit
        send_msg(1,  8'd6, 11'd3);   // single-byte message
        send_msg(8,  8'd5, 11'd2047);
        drain();

        // Back-pressure: tready must drop once the pack register is full
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        fork
            send_msg(24, 8'd11, 11'd100);
            begin
                repeat (12) @(negedge clk);
                check("stall_tready", 64'(s_axis_tready), 64'd0);
                check("stall_valid",  64'(network_valid_o), 64'd1);
                check("stall_type",   64'(network_flit_type_o), 64'd0);
                ready_mode = 2;
            end
        join
        drain();

        // Randomized messages with input gaps and random NoC back-pressure
        gap_en     = 1'b1;
        ready_mode = 2;
        for (int m = 0; m < 30; m++) begin
            send_msg($urandom_range(1, 40), 8'($urandom), 11'($urandom));
        end
        drain();
        gap_en = 1'b0;

        // Asynchronous reset in the middle of a packet
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b0;
        s_axis_tid    = 8'd1;
        s_axis_tdest  = 11'd2;
        s_axis_tdata  = 8'($urandom);
        repeat (4) begin
            @(posedge clk);
            #1;
            s_axis_tdata = 8'($urandom);
        end
        check("pre_reset_valid", 64'(network_valid_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 64'(network_valid_o), 64'd0);
        check("async_reset_flit",  network_flit_o, 64'd0);
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post_reset_tready", 64'(s_axis_tready), 64'd1);
        ready_mode = 2;
        send_msg(10, 8'd8, 11'd33);  // fresh header with cont=0
        drain();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_noc_packet_creator_gen
`default_nettype wire
